// File: rtl/pipe_pkg.sv
// Shared types for the pipeline control stage: ALUOp codes, forwarding selects, stage bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

   localparam int PIPE_REG_AW  = 5;
   localparam int PIPE_ALUOP_W = 2;

   // ALUOp encodings produced by the opcode decoder
   typedef enum logic [PIPE_ALUOP_W-1:0] {
      ALUOP_ADD   = 2'b00,   // loads / stores: address add
      ALUOP_SUB   = 2'b01,   // beq compare
      ALUOP_FUNCT = 2'b10    // R-type: ALU decodes funct field
   } alu_op_e;

   // ALU operand source selects
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [PIPE_REG_AW-1:0] REG_ZERO = '0;

   // ID/EX stage register
   typedef struct packed {
      logic [PIPE_REG_AW-1:0]  rs;
      logic [PIPE_REG_AW-1:0]  rt;
      logic [PIPE_REG_AW-1:0]  wreg;
      logic [PIPE_ALUOP_W-1:0] alu_op;
      logic                    alu_src;
      logic                    reg_write;
      logic                    mem_to_reg;
      logic                    mem_write;
   } idex_t;

   // EX/MEM stage register
   typedef struct packed {
      logic [PIPE_REG_AW-1:0] wreg;
      logic                   reg_write;
      logic                   mem_to_reg;
      logic                   mem_write;
   } exmem_t;

   // MEM/WB stage register
   typedef struct packed {
      logic [PIPE_REG_AW-1:0] wreg;
      logic                   reg_write;
      logic                   mem_to_reg;
   } memwb_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use and branch-operand hazard detection; produces stall and IF/ID flush.
// Latency: purely combinational (0 cycles).
// Backpressure: stall holds PC and IF/ID; a stall suppresses the flush in the same cycle.
// Ports: ID-stage branch/jump/eq/rs/rt, EX load/write/wreg, MEM load/wreg in; stall_o, flush_o out.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic                   id_is_branch_i,
   input  logic                   id_is_jump_i,
   input  logic                   id_eq_i,
   input  logic [PIPE_REG_AW-1:0] id_rs_i,
   input  logic [PIPE_REG_AW-1:0] id_rt_i,
   input  logic                   ex_mem_read_i,
   input  logic                   ex_reg_write_i,
   input  logic [PIPE_REG_AW-1:0] ex_wreg_i,
   input  logic                   mem_mem_read_i,
   input  logic [PIPE_REG_AW-1:0] mem_wreg_i,
   output logic                   stall_o,
   output logic                   flush_o
);

   logic ex_hit;
   logic mem_hit;
   logic load_use;
   logic br_ex;
   logic br_mem;

   // $0 is hard-wired, so a zero destination never creates a dependency
   assign ex_hit  = (ex_wreg_i != REG_ZERO) &&
                    ((ex_wreg_i == id_rs_i) || (ex_wreg_i == id_rt_i));
   assign mem_hit = (mem_wreg_i != REG_ZERO) &&
                    ((mem_wreg_i == id_rs_i) || (mem_wreg_i == id_rt_i));

   assign load_use = ex_mem_read_i & ex_hit;
   // Branch compares in ID, so it must wait for an ALU result still in EX
   // or for load data that is still in MEM.
   assign br_ex    = id_is_branch_i & ex_reg_write_i & ex_hit;
   assign br_mem   = id_is_branch_i & mem_mem_read_i & mem_hit;

   assign stall_o = load_use | br_ex | br_mem;
   // A stalled branch is re-evaluated next cycle, so it must not flush yet.
   assign flush_o = ~stall_o & ((id_is_branch_i & id_eq_i) | id_is_jump_i);

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Carries decoded controls through ID/EX, EX/MEM, MEM/WB; drives stall/flush and EX forwarding.
// Latency: ID->EX 1, ID->MEM 2, ID->WB 3 cycles; stall/flush/forward selects combinational.
// Backpressure: only hazard stall (holds PC and IF/ID, injects an ID/EX bubble); later stages always advance.
// Ports: clk_i/rst_i; id_* decoder controls and rs/rt/rd in; pc_write_o, ifid_write_o, ifid_flush_o,
//        fwd_a_o/fwd_b_o, registered ex_*, mem_* and wb_* controls out.
module pipe_ctrl_stage
   import pipe_pkg::*;
#(
   parameter int REG_AW  = PIPE_REG_AW,
   parameter int ALUOP_W = PIPE_ALUOP_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               id_reg_dst_i,
   input  logic [ALUOP_W-1:0] id_alu_op_i,
   input  logic               id_alu_src_i,
   input  logic               id_reg_write_i,
   input  logic               id_mem_to_reg_i,
   input  logic               id_mem_write_i,
   input  logic               id_is_branch_i,
   input  logic               id_is_jump_i,
   input  logic               id_eq_i,
   input  logic [REG_AW-1:0]  id_rs_i,
   input  logic [REG_AW-1:0]  id_rt_i,
   input  logic [REG_AW-1:0]  id_rd_i,
   output logic               pc_write_o,
   output logic               ifid_write_o,
   output logic               ifid_flush_o,
   output logic [ALUOP_W-1:0] ex_alu_op_o,
   output logic               ex_alu_src_o,
   output logic [1:0]         fwd_a_o,
   output logic [1:0]         fwd_b_o,
   output logic               mem_mem_write_o,
   output logic               mem_mem_read_o,
   output logic               wb_reg_write_o,
   output logic               wb_mem_to_reg_o,
   output logic [REG_AW-1:0]  wb_wreg_o
);

   idex_t  idex_d,  idex_q;
   exmem_t exmem_d, exmem_q;
   memwb_t memwb_d, memwb_q;

   logic [REG_AW-1:0] wreg;
   logic              ctrl_xfer;
   logic              reg_write_eff;
   logic              stall;
   logic              flush;

   // ---------------- entry gating ----------------
   assign wreg          = id_reg_dst_i ? id_rd_i : id_rt_i;
   assign ctrl_xfer     = id_is_branch_i | id_is_jump_i;
   assign reg_write_eff = id_reg_write_i & ~ctrl_xfer & (wreg != REG_ZERO);

   hazard_detect u_hazard (
      .id_is_branch_i (id_is_branch_i),
      .id_is_jump_i   (id_is_jump_i),
      .id_eq_i        (id_eq_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .ex_mem_read_i  (idex_q.mem_to_reg),
      .ex_reg_write_i (idex_q.reg_write),
      .ex_wreg_i      (idex_q.wreg),
      .mem_mem_read_i (exmem_q.mem_to_reg),
      .mem_wreg_i     (exmem_q.wreg),
      .stall_o        (stall),
      .flush_o        (flush)
   );

   // ---------------- next-state ----------------
   always_comb begin
      idex_d = '0;  // a stall loads a bubble
      if (!stall) begin
         idex_d.rs         = id_rs_i;
         idex_d.rt         = id_rt_i;
         idex_d.alu_op     = id_alu_op_i;
         idex_d.alu_src    = id_alu_src_i;
         idex_d.reg_write  = reg_write_eff;
         // Branches/jumps finish in ID: they travel on as no-write, no-mem slots
         idex_d.mem_to_reg = id_mem_to_reg_i & ~ctrl_xfer;
         idex_d.mem_write  = id_mem_write_i & ~ctrl_xfer;
         idex_d.wreg       = ctrl_xfer ? REG_ZERO : wreg;
      end

      exmem_d            = '0;
      exmem_d.wreg       = idex_q.wreg;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.mem_write  = idex_q.mem_write;

      memwb_d            = '0;
      memwb_d.wreg       = exmem_q.wreg;
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   // ---------------- forwarding ----------------
   // EX/MEM is checked first because it holds the younger (newer) value.
   always_comb begin
      fwd_a_o = FWD_REG;
      fwd_b_o = FWD_REG;
      if (!rst_i) begin
         if (exmem_q.reg_write && (exmem_q.wreg != REG_ZERO) && (exmem_q.wreg == idex_q.rs))
            fwd_a_o = FWD_EXMEM;
         else if (memwb_q.reg_write && (memwb_q.wreg != REG_ZERO) && (memwb_q.wreg == idex_q.rs))
            fwd_a_o = FWD_MEMWB;

         if (exmem_q.reg_write && (exmem_q.wreg != REG_ZERO) && (exmem_q.wreg == idex_q.rt))
            fwd_b_o = FWD_EXMEM;
         else if (memwb_q.reg_write && (memwb_q.wreg != REG_ZERO) && (memwb_q.wreg == idex_q.rt))
            fwd_b_o = FWD_MEMWB;
      end
   end

   // ---------------- outputs ----------------
   // Reset overrides any hazard computed from stage contents about to be cleared.
   assign pc_write_o      = rst_i | ~stall;
   assign ifid_write_o    = rst_i | ~stall;
   assign ifid_flush_o    = ~rst_i & flush;

   assign ex_alu_op_o     = idex_q.alu_op;
   assign ex_alu_src_o    = idex_q.alu_src;
   assign mem_mem_write_o = exmem_q.mem_write;
   assign mem_mem_read_o  = exmem_q.mem_to_reg;
   assign wb_reg_write_o  = memwb_q.reg_write;
   assign wb_mem_to_reg_o = memwb_q.mem_to_reg;
   assign wb_wreg_o       = memwb_q.wreg;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Scoreboard bench for pipe_ctrl_stage: per-instruction table with hand-derived stall,
// flush and forwarding expectations; registered stage outputs tracked through queues.
module tb_pipe_ctrl_stage;
   import pipe_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       id_reg_dst_i;
   logic [1:0] id_alu_op_i;
   logic       id_alu_src_i;
   logic       id_reg_write_i;
   logic       id_mem_to_reg_i;
   logic       id_mem_write_i;
   logic       id_is_branch_i;
   logic       id_is_jump_i;
   logic       id_eq_i;
   logic [4:0] id_rs_i, id_rt_i, id_rd_i;
   logic       pc_write_o, ifid_write_o, ifid_flush_o;
   logic [1:0] ex_alu_op_o;
   logic       ex_alu_src_o;
   logic [1:0] fwd_a_o, fwd_b_o;
   logic       mem_mem_write_o, mem_mem_read_o;
   logic       wb_reg_write_o, wb_mem_to_reg_o;
   logic [4:0] wb_wreg_o;

   always #5 clk_i = ~clk_i;

   pipe_ctrl_stage #(.REG_AW(5), .ALUOP_W(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_reg_dst_i(id_reg_dst_i), .id_alu_op_i(id_alu_op_i), .id_alu_src_i(id_alu_src_i),
      .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
      .id_mem_write_i(id_mem_write_i), .id_is_branch_i(id_is_branch_i),
      .id_is_jump_i(id_is_jump_i), .id_eq_i(id_eq_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
      .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
      .mem_mem_write_o(mem_mem_write_o), .mem_mem_read_o(mem_mem_read_o),
      .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
      .wb_wreg_o(wb_wreg_o)
   );

   typedef struct {
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       alu_src, reg_write, mem_to_reg, mem_write, br, jmp, eq;
      logic [4:0] rs, rt, rd;
      int         stalls;   // expected stall cycles before it enters ID/EX
      logic       flush;    // expected ifid_flush_o on the entering cycle
      logic [1:0] fa, fb;   // expected forward selects while it sits in EX
   } instr_t;

   typedef struct {
      logic [1:0] alu_op;
      logic       alu_src, mem_write, mem_read, reg_write, mem_to_reg;
      logic [4:0] wreg;
      logic [1:0] fa, fb;
   } exp_t;

   exp_t   q_ex[$], q_mem[$], q_wb[$];
   exp_t   cur_ex;
   bit     have_ex = 0;
   int     checks = 0;
   int     failures = 0;
   int     idx = 0;
   instr_t prog[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s (instr %0d) got=%0h expected=%0h", tag, idx, got, exp);
      end
   endtask

   function automatic instr_t blank();
      instr_t i;
      i = '{default: '0};
      i.stalls = 0;
      return i;
   endfunction

   function automatic instr_t alu(input logic [4:0] rs, rt, rd, input int st, input logic [1:0] fa, fb);
      instr_t i = blank();
      i.reg_dst = 1; i.alu_op = ALUOP_FUNCT; i.reg_write = 1;
      i.rs = rs; i.rt = rt; i.rd = rd; i.stalls = st; i.fa = fa; i.fb = fb;
      return i;
   endfunction

   function automatic instr_t lw(input logic [4:0] rs, rt, input int st, input logic [1:0] fa, fb);
      instr_t i = blank();
      i.alu_op = ALUOP_ADD; i.alu_src = 1; i.reg_write = 1; i.mem_to_reg = 1;
      i.rs = rs; i.rt = rt; i.stalls = st; i.fa = fa; i.fb = fb;
      return i;
   endfunction

   function automatic instr_t sw(input logic [4:0] rs, rt);
      instr_t i = blank();
      i.alu_op = ALUOP_ADD; i.alu_src = 1; i.mem_write = 1; i.rs = rs; i.rt = rt;
      return i;
   endfunction

   function automatic instr_t beq(input logic [4:0] rs, rt, input logic eq, rw, input int st,
                                  input logic fl, input logic [1:0] fa, fb);
      instr_t i = blank();
      i.br = 1; i.alu_op = ALUOP_SUB; i.eq = eq; i.reg_write = rw;
      i.rs = rs; i.rt = rt; i.stalls = st; i.flush = fl; i.fa = fa; i.fb = fb;
      return i;
   endfunction

   // Entry gating as described for the decoder bundle
   function automatic exp_t mk_exp(input instr_t i);
      exp_t e;
      logic [4:0] w;
      logic       cx;
      w  = i.reg_dst ? i.rd : i.rt;
      cx = i.br | i.jmp;
      e.alu_op     = i.alu_op;
      e.alu_src    = i.alu_src;
      e.reg_write  = i.reg_write & ~cx & (w != 5'd0);
      e.mem_read   = i.mem_to_reg & ~cx;
      e.mem_to_reg = i.mem_to_reg & ~cx;
      e.mem_write  = i.mem_write & ~cx;
      e.wreg       = cx ? 5'd0 : w;
      e.fa         = i.fa;
      e.fb         = i.fb;
      return e;
   endfunction

   task automatic drive(input instr_t i);
      id_reg_dst_i = i.reg_dst; id_alu_op_i = i.alu_op; id_alu_src_i = i.alu_src;
      id_reg_write_i = i.reg_write; id_mem_to_reg_i = i.mem_to_reg;
      id_mem_write_i = i.mem_write; id_is_branch_i = i.br; id_is_jump_i = i.jmp;
      id_eq_i = i.eq; id_rs_i = i.rs; id_rt_i = i.rt; id_rd_i = i.rd;
   endtask

   // Pop the stage scoreboards after a clock edge; each entry moves one stage per cycle.
   task automatic advance();
      exp_t e;
      if (q_wb.size() > 0) begin
         e = q_wb.pop_front();
         chk("wb_reg_write", wb_reg_write_o, e.reg_write);
         chk("wb_mem_to_reg", wb_mem_to_reg_o, e.mem_to_reg);
         chk("wb_wreg", wb_wreg_o, e.wreg);
      end
      if (q_mem.size() > 0) begin
         e = q_mem.pop_front();
         chk("mem_mem_write", mem_mem_write_o, e.mem_write);
         chk("mem_mem_read", mem_mem_read_o, e.mem_read);
         q_wb.push_back(e);
      end
      if (q_ex.size() > 0) begin
         e = q_ex.pop_front();
         chk("ex_alu_op", ex_alu_op_o, e.alu_op);
         chk("ex_alu_src", ex_alu_src_o, e.alu_src);
         q_mem.push_back(e);
         cur_ex  = e;
         have_ex = 1;
      end
   endtask

   task automatic cycle(input instr_t i, input bit exp_stall, input exp_t push);
      drive(i);
      @(negedge clk_i);
      chk("pc_write", pc_write_o, !exp_stall);
      chk("ifid_write", ifid_write_o, !exp_stall);
      chk("ifid_flush", ifid_flush_o, exp_stall ? 1'b0 : i.flush);
      if (have_ex) begin
         chk("fwd_a", fwd_a_o, cur_ex.fa);
         chk("fwd_b", fwd_b_o, cur_ex.fb);
      end
      q_ex.push_back(push);
      @(posedge clk_i);
      #1;
      advance();
   endtask

   task automatic run_instr(input instr_t i);
      exp_t bub;
      bub = '{default: '0};
      for (int s = 0; s < i.stalls; s++) cycle(i, 1'b1, bub);
      cycle(i, 1'b0, mk_exp(i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t j;
      drive(blank());
      rst_i = 1'b1;
      // ---- reset ----
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rst_pc_write", pc_write_o, 1'b1);
      chk("rst_ifid_write", ifid_write_o, 1'b1);
      chk("rst_ifid_flush", ifid_flush_o, 1'b0);
      chk("rst_fwd_a", fwd_a_o, 2'b00);
      chk("rst_fwd_b", fwd_b_o, 2'b00);
      chk("rst_ex_alu_op", ex_alu_op_o, 2'b00);
      chk("rst_ex_alu_src", ex_alu_src_o, 1'b0);
      chk("rst_mem_write", mem_mem_write_o, 1'b0);
      chk("rst_mem_read", mem_mem_read_o, 1'b0);
      chk("rst_wb_reg_write", wb_reg_write_o, 1'b0);
      chk("rst_wb_mem_to_reg", wb_mem_to_reg_o, 1'b0);
      chk("rst_wb_wreg", wb_wreg_o, 5'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // ---- program (fwd/stall/flush derived by hand from stage contents) ----
      prog.push_back(lw(5'd1, 5'd2, 0, 2'b00, 2'b00));                 // i0  lw $2
      prog.push_back(alu(5'd2, 5'd5, 5'd6, 1, 2'b01, 2'b00));          // i1  load-use, then MEM/WB fwd
      prog.push_back(alu(5'd7, 5'd8, 5'd9, 0, 2'b00, 2'b00));          // i2
      prog.push_back(alu(5'd10, 5'd11, 5'd3, 0, 2'b00, 2'b00));        // i3  add rd=3
      prog.push_back(alu(5'd3, 5'd3, 5'd12, 0, 2'b10, 2'b10));         // i4  sub 3,3 back-to-back
      prog.push_back(alu(5'd13, 5'd14, 5'd17, 0, 2'b00, 2'b00));       // i5  add rd=17
      prog.push_back(alu(5'd18, 5'd19, 5'd20, 0, 2'b00, 2'b00));       // i6  independent
      prog.push_back(alu(5'd17, 5'd17, 5'd21, 0, 2'b01, 2'b01));       // i7  one gap -> MEM/WB
      prog.push_back(alu(5'd0, 5'd0, 5'd22, 0, 2'b00, 2'b00));         // i8  rd=22
      prog.push_back(alu(5'd1, 5'd1, 5'd22, 0, 2'b00, 2'b00));         // i9  rd=22 again
      prog.push_back(alu(5'd22, 5'd1, 5'd23, 0, 2'b10, 2'b00));        // i10 EX/MEM beats MEM/WB
      prog.push_back(beq(5'd24, 5'd25, 1'b1, 1'b1, 0, 1'b1, 2'b00, 2'b00)); // i11 taken, no hazard
      prog.push_back(alu(5'd26, 5'd27, 5'd4, 0, 2'b00, 2'b00));        // i12 add rd=4
      prog.push_back(beq(5'd4, 5'd28, 1'b1, 1'b0, 1, 1'b1, 2'b01, 2'b00));  // i13 br_ex stall
      prog.push_back(lw(5'd1, 5'd29, 0, 2'b00, 2'b00));                // i14 lw $29
      prog.push_back(alu(5'd30, 5'd31, 5'd8, 0, 2'b00, 2'b00));        // i15
      prog.push_back(beq(5'd29, 5'd0, 1'b0, 1'b0, 1, 1'b0, 2'b00, 2'b00));  // i16 br_mem stall
      j = blank(); j.jmp = 1'b1; j.flush = 1'b1;
      prog.push_back(j);                                               // i17 jump
      prog.push_back(alu(5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00));          // i18 writes $0
      prog.push_back(lw(5'd0, 5'd5, 0, 2'b00, 2'b00));                 // i19 uses $0
      prog.push_back(lw(5'd3, 5'd0, 0, 2'b00, 2'b00));                 // i20 lw $0
      prog.push_back(alu(5'd0, 5'd0, 5'd7, 0, 2'b00, 2'b00));          // i21 no load-use on $0
      prog.push_back(sw(5'd1, 5'd5));                                  // i22 store
      for (int k = 0; k < 4; k++) prog.push_back(blank());             // drain

      foreach (prog[k]) begin
         idx = k;
         run_instr(prog[k]);
      end

      // ---- reset in the middle of a load-use stall ----
      q_ex.delete(); q_mem.delete(); q_wb.delete();
      idx = 100;
      run_instr(lw(5'd1, 5'd2, 0, 2'b00, 2'b00));
      q_ex.delete(); q_mem.delete(); q_wb.delete();
      idx = 101;
      drive(alu(5'd2, 5'd2, 5'd6, 0, 2'b00, 2'b00));
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rstmid_pc_write", pc_write_o, 1'b1);
      chk("rstmid_ifid_write", ifid_write_o, 1'b1);
      chk("rstmid_flush", ifid_flush_o, 1'b0);
      chk("rstmid_fwd_a", fwd_a_o, 2'b00);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("rstmid_ex_alu_op", ex_alu_op_o, 2'b00);
      chk("rstmid_mem_read", mem_mem_read_o, 1'b0);
      chk("rstmid_wb_reg_write", wb_reg_write_o, 1'b0);
      chk("rstmid_wb_wreg", wb_wreg_o, 5'd0);
      @(negedge clk_i);
      chk("rstmid_no_stall_after", pc_write_o, 1'b1);
      chk("rstmid_fwd_b_after", fwd_b_o, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
